// File: rtl/mem_responder_if.sv
// Memory request/grant/response bus between an initiator (core or cache)
// and a memory responder.
interface mem_responder_if;
    logic        mem_req;
    logic [31:0] mem_adr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_read;

    modport master (
        output mem_req, mem_adr, mem_we, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_read
    );

    modport slave (
        input  mem_req, mem_adr, mem_we, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_read
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port word memory answering req/gnt/rvalid requests one at a time,
// with programmable grant and response latencies and byte-enabled writes.
module mem_responder #(
    parameter int LOG_DEPTH    = 10,
    parameter int GNT_DELAY    = 0,
    parameter int RVALID_DELAY = 0
) (
    input  logic            clk,
    input  logic            res,
    mem_responder_if.slave  bus
);
    localparam int DEPTH     = 2 ** LOG_DEPTH;
    localparam int MAX_DELAY = (GNT_DELAY > RVALID_DELAY) ? GNT_DELAY : RVALID_DELAY;
    localparam int CNT_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam logic [CNT_W-1:0] GNT_LOAD  = CNT_W'((GNT_DELAY > 0) ? GNT_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] RESP_LOAD = CNT_W'((RVALID_DELAY > 0) ? RVALID_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_GNT  = 3'd1,
        GRANT     = 3'd2,
        WAIT_RESP = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   rvalid_r;
    logic [31:0]            read_r;
    logic                   access_s;
    logic [LOG_DEPTH-1:0]   idx_s;
    logic [31:0]            mem_r [DEPTH];
    logic                   unused_s;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    assign idx_s    = bus.mem_adr[LOG_DEPTH+1:2];
    assign unused_s = ^{bus.mem_adr[31:LOG_DEPTH+2], bus.mem_adr[1:0]};
    // The grant is the only point where the bus is sampled and memory touched.
    assign access_s = (state_r == GRANT) && bus.mem_req;

    assign bus.mem_gnt    = access_s;
    assign bus.mem_rvalid = rvalid_r;
    assign bus.mem_read   = read_r;

    // Next-state and latency counter logic; RESP re-enters the IDLE decision.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE, RESP: begin
                if (!bus.mem_req) begin
                    state_nxt_s = IDLE;
                end else if (GNT_DELAY == 0) begin
                    state_nxt_s = GRANT;
                end else begin
                    state_nxt_s = WAIT_GNT;
                    cnt_nxt_s   = GNT_LOAD;
                end
            end
            WAIT_GNT: begin
                if (!bus.mem_req) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = GRANT;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            GRANT: begin
                if (!bus.mem_req) begin
                    state_nxt_s = IDLE;
                end else if (RVALID_DELAY == 0) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT_RESP;
                    cnt_nxt_s   = RESP_LOAD;
                end
            end
            WAIT_RESP: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = RESP;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered response strobe.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            rvalid_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            rvalid_r <= (state_nxt_s == RESP);
        end
    end

    // Read data register; writes leave it untouched.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            read_r <= 32'h0000_0000;
        end else if (access_s && !bus.mem_we) begin
            read_r <= mem_r[idx_s];
        end
    end

    // Storage array is deliberately not reset so contents survive res.
    always_ff @(posedge clk) begin
        if (access_s && bus.mem_we) begin
            mem_r[idx_s] <= merge_bytes(mem_r[idx_s], bus.mem_wdata, bus.mem_be);
        end
    end
endmodule
